mm2x2_job_scheduler: RTL and testbench

Round-robin scheduler that shares one free-running 2x2 matrix-multiply engine between two requesters. Each requester hands over a complete job: matrix A and matrix B, each four 8-bit elements in row-major order. The scheduler serialises the job onto the engine's byte-wide A/B input streams in lock-step with the engine's fixed 13-cycle frame, captures the four serial result bytes, and returns them as one packed, tagged response. It sits between the host-side job sources and the engine, and takes the same clk/rst_n as the engine.

---
 rtl/mm2x2_pkg.sv | 26 ++
 rtl/rr_arbiter2.sv | 35 +++
 rtl/mm2x2_job_scheduler.sv | 140 ++++++++++++++
 tb/tb_mm2x2_job_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm2x2_pkg.sv
// Shared constants for the 2x2 matrix-multiply engine frame and its job scheduler.
package mm2x2_pkg;

    localparam int ELEM_W = 8;

    // Engine frame phases (one frame = PH_LAST+1 cycles)
    localparam logic [3:0] PH_LAST = 4'd12;
    localparam logic [3:0] PH_A0   = 4'd0;
    localparam logic [3:0] PH_B0   = 4'd4;
    localparam logic [3:0] PH_COMP = 4'd8;
    localparam logic [3:0] PH_C00  = 4'd10;
    localparam logic [3:0] PH_C11  = 4'd0;
    localparam logic [3:0] PH_RSP  = 4'd1;

    // Pick element 'off' (0..3) out of a packed {E3,E2,E1,E0} matrix word.
    function automatic logic [ELEM_W-1:0] elem_sel(input logic [4*ELEM_W-1:0] m,
                                                   input logic [3:0]          off);
        case (off)
            4'd0:    return m[1*ELEM_W-1:0*ELEM_W];
            4'd1:    return m[2*ELEM_W-1:1*ELEM_W];
            4'd2:    return m[3*ELEM_W-1:2*ELEM_W];
            default: return m[4*ELEM_W-1:3*ELEM_W];
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-bit pointer names the favoured requester
// when both are valid; the pointer moves past the winner on each update strobe.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] valid,
    input  logic       upd,
    output logic [1:0] grant
);

    logic ptr;

    // Combinational grant: lone requester wins, ties go to the pointer
    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // Pointer flips to the requester that did not win
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= 1'b0;
        else if (upd)
            ptr <= ~grant[1];
    end

endmodule

// File: rtl/mm2x2_job_scheduler.sv
// Shares one free-running 2x2 matmul engine between two requesters: grants a
// job at the end of each frame, streams it onto the engine byte inputs in the
// following frame, collects the four result bytes and returns a tagged response.
module mm2x2_job_scheduler
    import mm2x2_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [31:0]       req_a0,
    input  logic [31:0]       req_a1,
    input  logic [31:0]       req_b0,
    input  logic [31:0]       req_b1,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [31:0]       rsp_c,
    output logic [ELEM_W-1:0] eng_a,
    output logic [ELEM_W-1:0] eng_b,
    input  logic [ELEM_W-1:0] eng_c,
    output logic              frame_sync,
    output logic [7:0]        jobs_done
);

    localparam logic [3:0] PH_C01 = PH_C00 + 4'd1;
    localparam logic [3:0] PH_C10 = PH_C00 + 4'd2;

    logic [3:0]        phase;
    logic [1:0]        grant;
    logic              accept;
    logic              acc_id;
    logic [31:0]       job_a;
    logic [31:0]       job_b;
    logic              job_id;
    logic              load_active;
    logic              cap_active;
    logic              res_id;
    logic [ELEM_W-1:0] c00;
    logic [ELEM_W-1:0] c01;
    logic [ELEM_W-1:0] c10;

    // Frame phase counter, locked to the engine by the shared reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            phase <= 4'd0;
        else if (phase == PH_LAST)
            phase <= 4'd0;
        else
            phase <= phase + 4'd1;
    end

    assign frame_sync = (phase == PH_A0);

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (phase == PH_LAST),
        .valid (req_valid),
        .upd   (accept),
        .grant (grant)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign acc_id    = grant[1];

    // Job operands; only meaningful while load_active, so no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            job_a <= acc_id ? req_a1 : req_a0;
            job_b <= acc_id ? req_b1 : req_b0;
        end
    end

    // Decide at the frame boundary whether the next frame carries a job
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_active <= 1'b0;
            job_id      <= 1'b0;
        end else if (phase == PH_LAST) begin
            load_active <= accept;
            if (accept)
                job_id <= acc_id;
        end
    end

    // Stream A bytes then B bytes onto the engine; zeros otherwise
    always_comb begin
        eng_a = '0;
        eng_b = '0;
        if (load_active) begin
            if (phase < PH_B0)
                eng_a = elem_sel(job_a, phase - PH_A0);
            else if (phase < PH_COMP)
                eng_b = elem_sel(job_b, phase - PH_B0);
        end
    end

    // Hand the id to a separate result tag once the engine has computed,
    // freeing the job register for the next load while results drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_active <= 1'b0;
            res_id     <= 1'b0;
        end else if (phase == PH_COMP) begin
            cap_active <= load_active;
            res_id     <= job_id;
        end
    end

    // Capture the first three result bytes as the engine presents them
    always_ff @(posedge clk) begin
        if (cap_active) begin
            case (phase)
                PH_C00:  c00 <= eng_c;
                PH_C01:  c01 <= eng_c;
                PH_C10:  c10 <= eng_c;
                default: ;
            endcase
        end
    end

    // Assemble the response with C11 straight off the engine; one-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_c     <= '0;
            jobs_done <= '0;
        end else if (phase == PH_C11 && cap_active) begin
            rsp_valid <= 1'b1;
            rsp_id    <= res_id;
            rsp_c     <= {eng_c, c10, c01, c00};
            jobs_done <= jobs_done + 8'd1;
        end else if (phase == PH_RSP) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mm2x2_job_scheduler.sv
// Directed bench for mm2x2_job_scheduler with a behavioural 13-cycle matmul engine.
module tb_mm2x2_job_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_c;
    logic [7:0]  eng_a, eng_b, eng_c;
    logic        frame_sync;
    logic [7:0]  jobs_done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mm2x2_job_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_b0     (req_b0),
        .req_b1     (req_b1),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_c      (rsp_c),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_c      (eng_c),
        .frame_sync (frame_sync),
        .jobs_done  (jobs_done)
    );

    // Behavioural engine: own frame counter, samples A/B, computes, shifts out C
    logic [3:0] e_ph;
    logic [7:0] ea [4];
    logic [7:0] eb [4];
    logic [7:0] cm [4];
    logic [7:0] ec;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_ph <= 4'd0;
            ec   <= 8'd0;
        end else begin
            e_ph <= (e_ph == 4'd12) ? 4'd0 : e_ph + 4'd1;
            if (e_ph < 4'd4)
                ea[e_ph[1:0]] <= eng_a;
            else if (e_ph < 4'd8)
                eb[e_ph[1:0]] <= eng_b;
            if (e_ph == 4'd8) begin
                cm[0] <= ea[0] * eb[0] + ea[1] * eb[2];
                cm[1] <= ea[0] * eb[1] + ea[1] * eb[3];
                cm[2] <= ea[2] * eb[0] + ea[3] * eb[2];
                cm[3] <= ea[2] * eb[1] + ea[3] * eb[3];
            end
            case (e_ph)
                4'd9:    ec <= cm[0];
                4'd10:   ec <= cm[1];
                4'd11:   ec <= cm[2];
                4'd12:   ec <= cm[3];
                default: ec <= 8'd0;
            endcase
        end
    end

    assign eng_c = ec;

    always @(posedge clk) cyc <= cyc + 1;

    // Response log with the cycle stamp of each pulse
    logic [31:0] rq_c [$];
    logic        rq_id [$];
    int          rq_t [$];

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            rq_c.push_back(rsp_c);
            rq_id.push_back(rsp_id);
            rq_t.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        rq_c.delete();
        rq_id.delete();
        rq_t.delete();
    endtask

    task automatic wait_ph(input logic [3:0] p);
        int n;
        n = 0;
        @(negedge clk);
        while (e_ph != p && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (e_ph != p) begin
            fails++;
            $display("FAIL wait_ph: phase %0d, required %0d", e_ph, p);
        end
    endtask

    task automatic set_job(input logic id, input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            req_a1 = a;
            req_b1 = b;
        end else begin
            req_a0 = a;
            req_b0 = b;
        end
    endtask

    // Present valid in phase 12 and sample the combinational ready
    task automatic issue(input logic [1:0] vld, output logic [1:0] rdy, output int t);
        wait_ph(4'd12);
        req_valid = vld;
        #1;
        rdy = req_ready;
        t = cyc;
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b, required 00", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
        tests++; if (rsp_id !== 1'b0) begin fails++; $display("FAIL reset_rsp_id: got %b, required 0", rsp_id); end
        tests++; if (rsp_c !== 32'h0) begin fails++; $display("FAIL reset_rsp_c: got %h, required 0", rsp_c); end
        tests++; if (eng_a !== 8'h0 || eng_b !== 8'h0) begin fails++; $display("FAIL reset_eng: got %h/%h, required 00/00", eng_a, eng_b); end
        tests++; if (jobs_done !== 8'h0) begin fails++; $display("FAIL reset_jobs_done: got %0d, required 0", jobs_done); end
        tests++; if (frame_sync !== 1'b1) begin fails++; $display("FAIL reset_frame_sync: got %b, required 1", frame_sync); end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL ready_outside_ph12: got %b, required 00", req_ready); end
        tests++; if (frame_sync !== 1'b0) begin fails++; $display("FAIL frame_sync_ph1: got %b, required 0", frame_sync); end
        req_valid = 2'b00;
    endtask

    task automatic test_identity();
        logic [1:0]  rdy;
        int          t;
        logic [31:0] av, bv;
        logic [7:0]  xa, xb;
        av = 32'h01000001;
        bv = 32'h08070605;
        clear_log();
        set_job(1'b0, av, bv);
        issue(2'b01, rdy, t);
        tests++; if (rdy !== 2'b01) begin fails++; $display("FAIL identity_ready: got %b, required 01", rdy); end
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            if (p == 0) req_valid = 2'b00;
            xa = (p < 4) ? av[8*p +: 8] : 8'h00;
            xb = (p >= 4) ? bv[8*(p-4) +: 8] : 8'h00;
            tests++;
            if (eng_a !== xa || eng_b !== xb) begin
                fails++;
                $display("FAIL identity_stream ph%0d: got a=%h b=%h, required a=%h b=%h", p, eng_a, eng_b, xa, xb);
            end
        end
        wait_ph(4'd2);
        #1;
        tests++; if (rq_c.size() != 1) begin fails++; $display("FAIL identity_count: got %0d responses, required 1", rq_c.size()); end
        if (rq_c.size() > 0) begin
            tests++; if (rq_c[0] !== 32'h08070605) begin fails++; $display("FAIL identity_c: got %h, required 08070605", rq_c[0]); end
            tests++; if (rq_id[0] !== 1'b0) begin fails++; $display("FAIL identity_id: got %b, required 0", rq_id[0]); end
            tests++; if (rq_t[0] - t != 15) begin fails++; $display("FAIL identity_latency: got %0d, required 15", rq_t[0] - t); end
        end
        tests++; if (jobs_done !== 8'd1) begin fails++; $display("FAIL identity_jobs_done: got %0d, required 1", jobs_done); end
    endtask

    task automatic test_truncation();
        logic [1:0] rdy;
        int         t;
        clear_log();
        set_job(1'b0, 32'hC80000C8, 32'h02000002);
        issue(2'b01, rdy, t);
        tests++; if (rdy !== 2'b01) begin fails++; $display("FAIL trunc_ready: got %b, required 01", rdy); end
        @(negedge clk);
        req_valid = 2'b00;
        wait_ph(4'd12);
        wait_ph(4'd2);
        #1;
        tests++; if (rq_c.size() != 1) begin fails++; $display("FAIL trunc_count: got %0d responses, required 1", rq_c.size()); end
        if (rq_c.size() > 0) begin
            tests++; if (rq_c[0] !== 32'h90000090) begin fails++; $display("FAIL trunc_c: got %h, required 90000090", rq_c[0]); end
        end
        tests++; if (jobs_done !== 8'd2) begin fails++; $display("FAIL trunc_jobs_done: got %0d, required 2", jobs_done); end
    endtask

    task automatic test_idle();
        clear_log();
        wait_ph(4'd0);
        for (int p = 0; p < 13; p++) begin
            #1;
            tests++;
            if (eng_a !== 8'h00 || eng_b !== 8'h00) begin
                fails++;
                $display("FAIL idle_eng ph%0d: got a=%h b=%h, required 00/00", p, eng_a, eng_b);
            end
            if (p < 12) @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++; if (rsp_valid !== 1'b0 || rq_c.size() != 0) begin fails++; $display("FAIL idle_rsp: got valid=%b count=%0d, required 0/0", rsp_valid, rq_c.size()); end
        tests++; if (jobs_done !== 8'd2) begin fails++; $display("FAIL idle_jobs_done: got %0d, required 2", jobs_done); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] rdy;
        int         t1, t2;
        clear_log();
        set_job(1'b1, 32'h04030201, 32'h01010101);
        issue(2'b10, rdy, t1);
        tests++; if (rdy !== 2'b10) begin fails++; $display("FAIL b2b_ready1: got %b, required 10", rdy); end
        @(negedge clk);
        set_job(1'b1, 32'h02000002, 32'h06050403);
        issue(2'b10, rdy, t2);
        tests++; if (rdy !== 2'b10) begin fails++; $display("FAIL b2b_ready2: got %b, required 10", rdy); end
        tests++; if (t2 - t1 != 13) begin fails++; $display("FAIL b2b_grant_gap: got %0d, required 13", t2 - t1); end
        @(negedge clk);
        req_valid = 2'b00;
        wait_ph(4'd12);
        wait_ph(4'd2);
        #1;
        tests++; if (rq_c.size() != 2) begin fails++; $display("FAIL b2b_count: got %0d responses, required 2", rq_c.size()); end
        if (rq_c.size() > 1) begin
            tests++; if (rq_c[0] !== 32'h07070303) begin fails++; $display("FAIL b2b_c0: got %h, required 07070303", rq_c[0]); end
            tests++; if (rq_c[1] !== 32'h0C0A0806) begin fails++; $display("FAIL b2b_c1: got %h, required 0C0A0806", rq_c[1]); end
            tests++; if (rq_id[0] !== 1'b1 || rq_id[1] !== 1'b1) begin fails++; $display("FAIL b2b_id: got %b %b, required 1 1", rq_id[0], rq_id[1]); end
            tests++; if (rq_t[0] - t1 != 15) begin fails++; $display("FAIL b2b_latency: got %0d, required 15", rq_t[0] - t1); end
            tests++; if (rq_t[1] - rq_t[0] != 13) begin fails++; $display("FAIL b2b_spacing: got %0d, required 13", rq_t[1] - rq_t[0]); end
        end
        tests++; if (jobs_done !== 8'd4) begin fails++; $display("FAIL b2b_jobs_done: got %0d, required 4", jobs_done); end
    endtask

    task automatic test_reset_midframe();
        logic [1:0] rdy;
        int         t;
        clear_log();
        set_job(1'b0, 32'h01000001, 32'h08070605);
        issue(2'b01, rdy, t);
        tests++; if (rdy !== 2'b01) begin fails++; $display("FAIL midrst_ready: got %b, required 01", rdy); end
        @(negedge clk);
        req_valid = 2'b00;
        wait_ph(4'd5);
        #1;
        tests++; if (eng_b !== 8'h06) begin fails++; $display("FAIL midrst_pre_eng_b: got %h, required 06", eng_b); end
        rst_n = 1'b0;
        #1;
        tests++; if (eng_a !== 8'h00 || eng_b !== 8'h00) begin fails++; $display("FAIL midrst_eng: got %h/%h, required 00/00", eng_a, eng_b); end
        tests++; if (frame_sync !== 1'b1) begin fails++; $display("FAIL midrst_frame_sync: got %b, required 1", frame_sync); end
        tests++; if (jobs_done !== 8'd0) begin fails++; $display("FAIL midrst_jobs_done: got %0d, required 0", jobs_done); end
        tests++; if (rsp_id !== 1'b0 || rsp_c !== 32'h0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL midrst_rsp: got v=%b id=%b c=%h, required 0/0/0", rsp_valid, rsp_id, rsp_c); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        tests++; if (rq_c.size() != 0) begin fails++; $display("FAIL midrst_dropped: got %0d responses, required 0", rq_c.size()); end
        set_job(1'b1, 32'h02000002, 32'h06050403);
        issue(2'b10, rdy, t);
        tests++; if (rdy !== 2'b10) begin fails++; $display("FAIL midrst_ready2: got %b, required 10", rdy); end
        @(negedge clk);
        req_valid = 2'b00;
        wait_ph(4'd12);
        wait_ph(4'd2);
        #1;
        tests++; if (rq_c.size() != 1) begin fails++; $display("FAIL midrst_count: got %0d responses, required 1", rq_c.size()); end
        if (rq_c.size() > 0) begin
            tests++; if (rq_c[0] !== 32'h0C0A0806 || rq_id[0] !== 1'b1) begin fails++; $display("FAIL midrst_result: got c=%h id=%b, required 0C0A0806/1", rq_c[0], rq_id[0]); end
        end
        tests++; if (jobs_done !== 8'd1) begin fails++; $display("FAIL midrst_jobs_done_after: got %0d, required 1", jobs_done); end
    endtask

    task automatic test_contention();
        logic [1:0] rdy;
        logic [1:0] xr;
        int         t;
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b0;
        set_job(1'b0, 32'h01000001, 32'h08070605);
        set_job(1'b1, 32'h02000002, 32'h06050403);
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        clear_log();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            issue(2'b11, rdy, t);
            xr = (k % 2 == 0) ? 2'b01 : 2'b10;
            tests++; if (rdy !== xr) begin fails++; $display("FAIL contention_grant%0d: got %b, required %b", k, rdy, xr); end
        end
        @(negedge clk);
        req_valid = 2'b00;
        wait_ph(4'd12);
        wait_ph(4'd2);
        #1;
        tests++; if (rq_c.size() != 4) begin fails++; $display("FAIL contention_count: got %0d responses, required 4", rq_c.size()); end
        if (rq_c.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (rq_id[k] !== k[0] || rq_c[k] !== (k[0] ? 32'h0C0A0806 : 32'h08070605)) begin
                    fails++;
                    $display("FAIL contention_rsp%0d: got id=%b c=%h, required id=%0d", k, rq_id[k], rq_c[k], k % 2);
                end
            end
        end
        tests++; if (jobs_done !== 8'd4) begin fails++; $display("FAIL contention_jobs_done: got %0d, required 4", jobs_done); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_truncation();
        test_idle();
        test_back_to_back();
        test_reset_midframe();
        test_contention();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
